// File: rtl/collector_pkg.sv
// Shared definitions for the result collector: data width, buffer depth, FSM states.
package collector_pkg;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;
endpackage

// File: rtl/result_collector_if.sv
// Kernel-side input stream and consumer-side replay stream of the result collector.
interface result_collector_if;
    import collector_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index
    );
endinterface

// File: rtl/result_buf.sv
// DEPTH x DATA_W result storage: synchronous write, combinational read, no reset.
module result_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/result_collector.sv
// Captures n kernel results, then replays them in index order with done/err status.
// Optional RESULT_CHECKSUM_EN adds a modulo-2^DATA_W sum of the captured inputs.
module result_collector
    import collector_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        n,
    result_collector_if.slave  bus,
    output logic [IDX_W:0]     count,
    output logic               done,
    output logic               err
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]  checksum
`endif
);
    state_e            state_q, state_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [IDX_W:0]    target_q, target_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;
    logic [IDX_W:0]    count_inc;
    logic [IDX_W:0]    last_idx;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    assign count_inc = count_q + 1'b1;
    assign last_idx  = target_q - 1'b1;

    result_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (count_q[IDX_W-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef RESULT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        target_d      = target_q;
        rd_ptr_d      = rd_ptr_q;
        done_d        = 1'b0;
        err_d         = err_q;
        buf_we        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_index = '0;
`ifdef RESULT_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n == 32'd0) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else if (n > 32'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        count_d  = '0;
                        target_d = n[IDX_W:0];
                        state_d  = COLLECT;
`ifdef RESULT_CHECKSUM_EN
                        csum_d   = '0;
`endif
                    end
                end
            end
            COLLECT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    buf_we  = 1'b1;
                    count_d = count_inc;
`ifdef RESULT_CHECKSUM_EN
                    csum_d  = csum_q + bus.in_data;
`endif
                    if (count_inc == target_q) begin
                        state_d  = DRAIN;
                        rd_ptr_d = '0;
                    end
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = buf_rdata;
                bus.out_index = rd_ptr_q;
                if (bus.out_ready) begin
                    if ({1'b0, rd_ptr_q} == last_idx) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count = count_q;
    assign done  = done_q;
    assign err   = err_q;
`ifdef RESULT_CHECKSUM_EN
    assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_result_collector.sv
// Randomized self-checking bench for result_collector against a queue-style reference.
module tb_result_collector;
    import collector_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [31:0]       n;
    logic [IDX_W:0]    count;
    logic              done;
    logic              err;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    int tests;
    int fails;
    logic [31:0] src [0:31];

    result_collector_if bus ();

    result_collector dut (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .n     (n),
        .bus   (bus.slave),
        .count (count),
        .done  (done),
        .err   (err)
`ifdef RESULT_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full run: start, feed src[0..nn-1], expect them replayed in order.
    // vmode 0 = in_valid continuous, 1 = random; rmode 0 = ready always,
    // 1 = ready pattern 1,0,0 repeating, 2 = random.
    task automatic run_case(input string name, input int nn, input int vmode,
                            input int rmode, input bit fire_mid_start);
        int sent, recv, cyc;
        bit fin, prev_stall;
        logic [DATA_W-1:0] prev_data, exp_sum;
        logic [IDX_W-1:0]  prev_idx;
        sent = 0; recv = 0; cyc = 1; fin = 0; prev_stall = 0;
        prev_data = '0; prev_idx = '0; exp_sum = '0;
        for (int k = 0; k < nn; k++) exp_sum = exp_sum + src[k];
        @(posedge clk); #1;
        start = 1'b1; n = nn; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            bus.in_valid = (sent < nn) && (vmode == 0 || $urandom_range(0, 1) == 1);
            bus.in_data  = src[sent];
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (c % 3 == 0);
                default: bus.out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (fire_mid_start && cyc == 2) begin
                start = 1'b1; n = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                fin = 1;
                tests++;
                if (recv !== nn) begin
                    fails++;
                    $display("FAIL %s done_early: received %0d, required %0d", name, recv, nn);
                end
                tests++;
                if (bus.out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s valid_with_done: out_valid %b, required 0", name, bus.out_valid);
                end
                if (vmode == 0 && rmode == 0) begin
                    tests++;
                    if (cyc !== 2 * nn + 1) begin
                        fails++;
                        $display("FAIL %s done_cycle: cycle %0d, required %0d", name, cyc, 2 * nn + 1);
                    end
                end
`ifdef RESULT_CHECKSUM_EN
                tests++;
                if (checksum !== exp_sum) begin
                    fails++;
                    $display("FAIL %s checksum: got %0d, required %0d", name, checksum, exp_sum);
                end
`endif
            end
            if (prev_stall) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_index !== prev_idx) begin
                    fails++;
                    $display("FAIL %s stall_hold: valid %b data %0d idx %0d, required 1 %0d %0d",
                             name, bus.out_valid, bus.out_data, bus.out_index, prev_data, prev_idx);
                end
            end
            if (bus.out_valid) begin
                tests++;
                if (recv >= nn) begin
                    fails++;
                    $display("FAIL %s extra_output: element %0d beyond n=%0d", name, recv, nn);
                end else if (bus.out_data !== src[recv] || bus.out_index !== IDX_W'(recv)) begin
                    fails++;
                    $display("FAIL %s replay: data %0d idx %0d, required %0d %0d",
                             name, bus.out_data, bus.out_index, src[recv], recv);
                end
            end
            if (sent >= nn) begin
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s in_ready_after_full: got %b, required 0", name, bus.in_ready);
                end
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) recv++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_index;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s timeout: no done, sent %0d received %0d", name, sent, recv);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || count !== (IDX_W + 1)'(nn == 0 ? count : nn) || err !== 1'b0) begin
            fails++;
            $display("FAIL %s after_done: done %b count %0d err %b, required 0 %0d 0",
                     name, done, count, err, nn);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            bus.out_data !== '0 || bus.out_index !== '0 || count !== '0) begin
            fails++;
            $display("FAIL reset_state: rdy %b vld %b done %b err %b data %0d idx %0d cnt %0d, required all 0",
                     bus.in_ready, bus.out_valid, done, err, bus.out_data, bus.out_index, count);
        end
    endtask

    task automatic test_nominal();
        src[0] = 32'd280; src[1] = 32'd910; src[2] = 32'd1900; src[3] = 32'd3250;
        run_case("nominal", 4, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_case("backpressure", 4, 0, 1, 0);
    endtask

    task automatic test_boundaries();
        run_case("n0", 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) src[k] = $urandom;
        run_case("n16", 16, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b1; n = 32'd17; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (err !== 1'b1 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL n17: err %b in_ready %b done %b, required 1 0 0", err, bus.in_ready, done);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        run_case("n2_after_err", 2, 0, 0, 0);
    endtask

    task automatic test_ignored_start();
        for (int k = 0; k < 16; k++) src[k] = $urandom;
        run_case("ignored_start", 3, 0, 0, 1);
    endtask

    task automatic test_reset_mid_run();
        for (int k = 0; k < 4; k++) src[k] = $urandom;
        @(posedge clk); #1;
        start = 1'b1; n = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = src[k];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd2 || bus.out_data !== src[2]) begin
            fails++;
            $display("FAIL mid_reset_pre: vld %b idx %0d data %0d, required 1 2 %0d",
                     bus.out_valid, bus.out_index, bus.out_data, src[2]);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_index !== '0 ||
            count !== '0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async: vld %b data %0d idx %0d cnt %0d done %b, required all 0",
                     bus.out_valid, bus.out_data, bus.out_index, count, done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_hold: done %b vld %b, required 0 0", done, bus.out_valid);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        src[0] = $urandom; src[1] = $urandom;
        run_case("after_reset", 2, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int nn;
            nn = $urandom_range(1, DEPTH);
            for (int k = 0; k < DEPTH; k++) src[k] = $urandom;
            run_case("random", nn, 1, 2, 0);
        end
    endtask

    task automatic test_checksum_wrap();
        src[0] = 32'hFFFF_FFFF; src[1] = 32'h2;
        run_case("wrap", 2, 0, 0, 0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; n = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        for (int k = 0; k < 32; k++) src[k] = '0;
        repeat (2) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_nominal();
        test_backpressure();
        test_boundaries();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        test_checksum_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
